// File: rtl/gate_exerciser.sv
// Two-input gate exerciser: drives every (a,b) vector for several rounds,
// compares the gate output against the selected function and counts mismatches.
module gate_exerciser #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned ROUNDS      = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       func,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned       CTR_W      = 8;
  localparam logic [CTR_W-1:0]  HOLD_LAST  = CTR_W'(HOLD_CYCLES - 1);
  localparam logic [CTR_W-1:0]  ROUND_LAST = CTR_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0]  ERR_MAX    = '1;

  state_t           state_q, state_d;
  logic [2:0]       func_q, func_d;
  logic [1:0]       idx_q, idx_d;
  logic [CTR_W-1:0] hold_q, hold_d;
  logic [CTR_W-1:0] round_q, round_d;
  logic             a_q, a_d, b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic expected_c;
  logic check_c;
  logic last_c;
  logic [1:0] idx_next_c;

  // Reference gate model for the latched function
  always_comb begin
    expected_c = a_q | b_q;
    case (func_q)
      3'b001:  expected_c = a_q & b_q;
      3'b010:  expected_c = a_q ^ b_q;
      3'b011:  expected_c = ~(a_q | b_q);
      3'b100:  expected_c = ~(a_q & b_q);
      3'b101:  expected_c = ~(a_q ^ b_q);
      default: expected_c = a_q | b_q;
    endcase
  end

  assign check_c    = (state_q == DRIVE) && (hold_q == HOLD_LAST);
  assign last_c     = check_c && (idx_q == 2'd3) && (round_q == ROUND_LAST);
  assign idx_next_c = idx_q + 2'd1;

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    round_d = round_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          func_d  = func;
          err_d   = '0;
          idx_d   = 2'd0;
          hold_d  = '0;
          round_d = '0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b1;
        end
      end
      DRIVE: begin
        if (check_c) begin
          if ((dut_c != expected_c) && (err_q != ERR_MAX)) begin
            err_d = err_q + CNT_W'(1);
          end
          hold_d = '0;
          if (last_c) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
            idx_d   = 2'd0;
            round_d = '0;
            a_d     = 1'b0;
            b_d     = 1'b0;
          end else begin
            // a is the low index bit so it toggles fastest: 00,10,01,11
            idx_d = idx_next_c;
            a_d   = idx_next_c[0];
            b_d   = idx_next_c[1];
            if (idx_q == 2'd3) begin
              round_d = round_q + CTR_W'(1);
            end
          end
        end else begin
          hold_d = hold_q + CTR_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      func_q  <= 3'b000;
      idx_q   <= 2'd0;
      hold_q  <= '0;
      round_q <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      round_q <= round_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  assign dut_a     = a_q;
  assign dut_b     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule
